instruction_fetch_unit: RTL

- Fetch stage of the MiniAlu core. Sits directly upstream of the instruction ROM: drives the ROM address and registers the 28-bit instruction the ROM returns.
- Resolves unconditional control flow locally: JMP, CALL, RET, with a hardware return-address stack.
- Accepts redirects for taken BLE branches from execute, and stalls on a busy downstream unit (e.g. the LCD writer).
- Hands one registered instruction per cycle to decode/execute.

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_ras.sv | 48 ++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// MiniAlu shared definitions: opcode encoding and instruction field positions.
// Combinational constants only; no latency or backpressure.
package instruction_fetch_unit_pkg;

  localparam int INSN_W  = 28;
  localparam int OPC_MSB = 27;
  localparam int OPC_LSB = 24;
  localparam int TGT_MSB = 23;
  localparam int TGT_LSB = 16;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    JMP  = 4'h1,
    CALL = 4'h2,
    RET  = 4'h3,
    BLE  = 4'h4
  } opcode_e;

  localparam logic [INSN_W-1:0] NOP_WORD = {NOP, {(INSN_W-4){1'b0}}};

endpackage

// File: rtl/instruction_fetch_unit_ras.sv
// Return-address stack: LIFO of STACK_DEPTH addresses, push/pop in one cycle, top is combinational.
// Push when full and pop when empty are ignored; the caller raises the error flags.
module return_address_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_dat,
  output logic [ADDR_W-1:0] top_dat,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = sp[IDX_W-1:0];
  assign rd_idx  = wr_idx - IDX_W'(1);
  assign top_dat = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entries carry no reset; only sp decides what is live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_dat;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MiniAlu fetch stage: drives ROM address, resolves JMP/CALL/RET locally, registers one instruction per cycle.
// One-cycle latency from oAddress to oInstruction; iStall freezes all state, iBranchTaken flushes one slot.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [7:0]        iBranchTarget,
  output logic [INSN_W-1:0] oInstruction,
  output logic              oValid,
  output logic              oStackOverflow,
  output logic              oStackUnderflow
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic [INSN_W-1:0] insn_q;
  logic              valid_q;
  logic              ovf_q;
  logic              udf_q;
  logic              advance;
  logic              is_call;
  logic              is_ret;
  logic              stk_full;
  logic              stk_empty;
  opcode_e           opc;

  assign opc      = opcode_e'(iInstruction[OPC_MSB:OPC_LSB]);
  assign pc_inc   = pc + ADDR_W'(1);
  assign tgt_addr = ADDR_W'(iInstruction[TGT_MSB:TGT_LSB]);
  // A flush or stall discards the fetched word, so it must not touch the stack.
  assign advance  = !iStall && !iBranchTaken;
  assign is_call  = advance && (opc == CALL);
  assign is_ret   = advance && (opc == RET);

  return_address_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ras (
    .clk      (Clock),
    .rst      (Reset),
    .push     (is_call),
    .pop      (is_ret),
    .push_dat (pc_inc),
    .top_dat  (ret_addr),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc      <= '0;
      insn_q  <= NOP_WORD;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (!iStall) begin
      insn_q  <= NOP_WORD;
      valid_q <= 1'b0;
      if (iBranchTaken) begin
        pc <= ADDR_W'(iBranchTarget);
      end else begin
        case (opc)
          JMP: pc <= tgt_addr;
          CALL: begin
            pc <= tgt_addr;
            if (stk_full) ovf_q <= 1'b1;
          end
          RET: begin
            if (stk_empty) begin
              udf_q <= 1'b1;
              pc    <= pc_inc;
            end else begin
              pc <= ret_addr;
            end
          end
          default: begin
            pc      <= pc_inc;
            insn_q  <= iInstruction;
            valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign oAddress        = pc;
  assign oInstruction    = insn_q;
  assign oValid          = valid_q;
  assign oStackOverflow  = ovf_q;
  assign oStackUnderflow = udf_q;

endmodule
